// File: rtl/hazard_scoreboard.sv
// Purpose : load-use hazard unit beside ID; stalls PC/IF-ID and bubbles ID/EX
//           while an in-flight load (up to LOAD_LAT cycles old) feeds an ID source.
// Latency : outputs are combinational from current inputs plus registered
//           scoreboard state; the scoreboard advances every clock.
// Backpressure: this block *is* the backpressure source; it never stalls itself.
// Ports   : clk/reset (async active-high); idExMemRead/idExRt describe the load in
//           ID/EX; ifIdValid/ifIdRs/ifIdRt/ifIdUsesRs/ifIdUsesRt describe the ID
//           consumer; flushIfId discards IF/ID; statsClear clears the counter;
//           pcWrite/ifIdWrite/bubbleInstruction are stall controls; pendingBusy
//           flags any registered entry; stallCycles is the stall counter.
// Option  : define HAZARD_STATS_EN to build the saturating stall counter;
//           otherwise stallCycles is tied to zero and statsClear is ignored.
module hazard_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              idExMemRead,
   input  logic [ADDR_W-1:0] idExRt,
   input  logic              ifIdValid,
   input  logic [ADDR_W-1:0] ifIdRs,
   input  logic [ADDR_W-1:0] ifIdRt,
   input  logic              ifIdUsesRs,
   input  logic              ifIdUsesRt,
   input  logic              flushIfId,
   input  logic              statsClear,
   output logic              pcWrite,
   output logic              ifIdWrite,
   output logic              bubbleInstruction,
   output logic              pendingBusy,
   output logic [15:0]       stallCycles
);

   // Registered entries are pend[1..LOAD_LAT-1]; index k here holds pend[k+1].
   // One dummy (always invalid) slot is kept when LOAD_LAT=1 so the arrays
   // never collapse to zero width.
   localparam int NREG = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

   logic              liveValid;
   logic [ADDR_W-1:0] liveAddr;
   logic [NREG-1:0]   regValid;
   logic [ADDR_W-1:0] regAddr [NREG];
   logic              anyMatch;
   logic              hazard;

   // A source hits an entry address when it is read and is not the hardwired
   // zero register.
   function automatic logic srcHit(input logic              useA,
                                   input logic              useB,
                                   input logic [ADDR_W-1:0] srcA,
                                   input logic [ADDR_W-1:0] srcB,
                                   input logic [ADDR_W-1:0] entAddr);
      logic hitA;
      logic hitB;
      hitA = useA && (srcA == entAddr) && !((ZERO_REG != 0) && (srcA == '0));
      hitB = useB && (srcB == entAddr) && !((ZERO_REG != 0) && (srcB == '0));
      return hitA || hitB;
   endfunction

   always_comb begin
      liveValid = idExMemRead && !((ZERO_REG != 0) && (idExRt == '0));
      liveAddr  = idExRt;
   end

   // All entries are OR-ed: overlapping matches yield one stall, which lasts
   // until the youngest matching entry has shifted out.
   always_comb begin
      anyMatch = liveValid && srcHit(ifIdUsesRs, ifIdUsesRt, ifIdRs, ifIdRt, liveAddr);
      for (int k = 0; k < NREG; k++) begin
         anyMatch = anyMatch ||
                    (regValid[k] && srcHit(ifIdUsesRs, ifIdUsesRt, ifIdRs, ifIdRt, regAddr[k]));
      end
      hazard = ifIdValid && !flushIfId && anyMatch;
   end

   assign pcWrite           = !hazard;
   assign ifIdWrite         = !hazard;
   assign bubbleInstruction = hazard;
   assign pendingBusy       = |regValid;

   generate
      if (LOAD_LAT > 1) begin : gPend
         // Free-running shift: stalls and flushes never freeze it. A stall
         // bubbles ID/EX, so the same load is not inserted twice.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               regValid <= '0;
               for (int k = 0; k < NREG; k++) begin
                  regAddr[k] <= '0;
               end
            end else begin
               regValid[0] <= liveValid;
               regAddr[0]  <= liveAddr;
               for (int k = 1; k < NREG; k++) begin
                  regValid[k] <= regValid[k-1];
                  regAddr[k]  <= regAddr[k-1];
               end
            end
         end
      end else begin : gNoPend
         assign regValid   = '0;
         assign regAddr[0] = '0;
      end
   endgenerate

`ifdef HAZARD_STATS_EN
   logic [15:0] statsCnt;

   // Clear wins over increment; the count saturates instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         statsCnt <= '0;
      end else if (statsClear) begin
         statsCnt <= '0;
      end else if (hazard && (statsCnt != 16'hFFFF)) begin
         statsCnt <= statsCnt + 16'd1;
      end
   end

   assign stallCycles = statsCnt;
`else
   logic unusedStatsClear;
   assign unusedStatsClear = statsClear;
   assign stallCycles      = 16'h0000;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised load-use hazard unit for the 5-stage pipeline; sits beside the ID stage and drives PC, IF/ID write-enable and the ID/EX bubble mux.
- Generalises single-bubble load-use detection to loads whose data becomes forwardable LOAD_LAT cycles after EX.
- Tracks in-flight load destinations in a shift-register scoreboard and honours source-use qualifiers, IF/ID validity and branch flush.

Parameters:
- ADDR_W, 5, register-address width.
- LOAD_LAT, 1, stall cycles required between a load in EX and a dependent instruction in ID (range 1..8); 1 gives classic single-bubble behaviour.
- ZERO_REG, 1, when 1 register address 0 never causes a hazard.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- idExMemRead  input  1  instruction in ID/EX is a load.
- idExRt  input  ADDR_W  load destination in ID/EX.
- ifIdValid  input  1  IF/ID holds a real instruction.
- ifIdRs  input  ADDR_W  source register 1 of the instruction in ID.
- ifIdRt  input  ADDR_W  source register 2 of the instruction in ID.
- ifIdUsesRs  input  1  instruction in ID reads Rs.
- ifIdUsesRt  input  1  instruction in ID reads Rt.
- flushIfId  input  1  branch taken this cycle; IF/ID contents are discarded.
- statsClear  input  1  synchronous clear of the stall counter.
- pcWrite  output  1  PC write enable.
- ifIdWrite  output  1  IF/ID write enable.
- bubbleInstruction  output  1  force control bits to zero into ID/EX.
- pendingBusy  output  1  any registered scoreboard entry is valid.
- stallCycles  output  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Scoreboard: entries pend[1..LOAD_LAT-1], each {valid, addr}; none exist when LOAD_LAT=1.
- Live entry pend[0] is combinational: valid = idExMemRead & !(ZERO_REG & idExRt==0); addr = idExRt.
- Every clock edge: pend[1] <= pend[0]; pend[k] <= pend[k-1] for k>=2. The scoreboard always advances; it is never frozen by stall or flush.
- A stall bubbles ID/EX, so idExMemRead drops the next cycle and no duplicate entry is inserted.
- Match for entry k: valid_k & ((ifIdUsesRs & ifIdRs==addr_k) | (ifIdUsesRt & ifIdRt==addr_k)).
- ZERO_REG=1: a source address of 0 never matches.
- hazard = ifIdValid & !flushIfId & (OR of matches over k=0..LOAD_LAT-1).
- Outputs, combinational from the registered state plus current inputs:
  - pcWrite = !hazard.
  - ifIdWrite = !hazard.
  - bubbleInstruction = hazard.
- pendingBusy = OR of valid over registered entries; it is 0 when LOAD_LAT=1.
- Latency: a consumer directly behind a load stalls exactly LOAD_LAT cycles. A consumer separated from the load by m independent instructions stalls max(0, LOAD_LAT-m) cycles.
- flushIfId has priority over hazard: outputs are 1/1/0 that cycle. Pending entries are kept, because the load itself is older and still valid.
- Simultaneous matches on several entries or both sources give a single stall, not an accumulated one. The stall releases when the youngest matching entry shifts out.
- Reset, asynchronous: all pend valid bits = 0 and stallCycles = 0. With idle inputs the outputs are pcWrite=1, ifIdWrite=1, bubbleInstruction=0, pendingBusy=0.
- Reset mid-stall: the stall ends immediately once the ID/EX inputs go idle.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stallCycles increments by 1 each clock with bubbleInstruction=1.
  - It saturates at 16'hFFFF.
  - statsClear=1 loads 0 at the next edge and takes priority over increment.
- Undefined:
  - stallCycles is tied to 16'h0000.
  - statsClear is ignored and no counter flops are built.

Test Plan:
- LOAD_LAT=1: load to r5, next instruction reads r5 via Rs (usesRs=1) -> exactly 1 cycle of pcWrite=0, ifIdWrite=0, bubbleInstruction=1, then 1/1/0.
- LOAD_LAT=3: load to r7, consumer reads r7 via Rt directly behind -> 3 bubble cycles. Same with 1 independent instruction between -> 2 bubble cycles. pendingBusy=1 for 2 cycles after the load leaves EX.
- Load to r0 with ZERO_REG=1, consumer reads r0 -> no stall. Load r9, consumer has Rt=9 but usesRt=0 -> no stall. ifIdValid=0 -> no stall.
- LOAD_LAT=2: load r4, consumer of r4 with flushIfId=1 in the first hazard cycle -> outputs 1/1/0 that cycle. A new consumer of r4 arriving the next cycle stalls 1 cycle, proving pend[1] survived the flush.
- Mid-stall with LOAD_LAT=3: assert reset asynchronously between edges -> outputs return to 1/1/0 with idle inputs, pendingBusy=0, stallCycles=0.
- HAZARD_STATS_EN defined: 5 stall cycles -> stallCycles=5. statsClear and a stall in the same cycle -> 0. Preload near 16'hFFFF and run 3 stall cycles -> holds 16'hFFFF. With the macro undefined -> always 0.
